// File: rtl/cheat_match_engine_if.sv
// Load, clear, CPU-bus and status signals of the cheat-code match engine.
// master drives loads and bus cycles; slave is the engine.
interface cheat_match_engine_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              enable;
  logic              load_valid;
  logic              load_ready;
  logic [4:0]        load_slot;
  logic              load_en;
  logic              load_cmp_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_cmp;
  logic [DATA_W-1:0] load_rep;
  logic              clear_req;
  logic              clear_busy;
  logic [ADDR_W:0]   bus_addr;
  logic [DATA_W-1:0] bus_data;
  logic              bus_rd;
  logic              ovr;
  logic [DATA_W-1:0] ovr_data;
  logic              hit_valid;
  logic [4:0]        hit_slot;
  logic [5:0]        active_count;

  modport master (
    output enable, load_valid, load_slot, load_en, load_cmp_en, load_addr,
           load_cmp, load_rep, clear_req, bus_addr, bus_data, bus_rd,
    input  load_ready, clear_busy, ovr, ovr_data, hit_valid, hit_slot, active_count
  );

  modport slave (
    input  enable, load_valid, load_slot, load_en, load_cmp_en, load_addr,
           load_cmp, load_rep, clear_req, bus_addr, bus_data, bus_rd,
    output load_ready, clear_busy, ovr, ovr_data, hit_valid, hit_slot, active_count
  );
endinterface

// File: rtl/cheat_match_engine.sv
// Cheat-code engine: watches ROM reads and substitutes data for matching slots,
// with a load port and a one-slot-per-clock wipe sequence.
module cheat_match_engine #(
  parameter int NUM_CODES = 16,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 8
) (
  input logic clk,
  input logic reset,
  cheat_match_engine_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [4:0]        ptr_reg, ptr_next;
  logic [NUM_CODES-1:0] en_reg;
  logic [NUM_CODES-1:0] cmp_en_reg;
  logic [ADDR_W-1:0] addr_reg [NUM_CODES];
  logic [DATA_W-1:0] cmp_reg  [NUM_CODES];
  logic [DATA_W-1:0] rep_reg  [NUM_CODES];

  logic [NUM_CODES-1:0] match;
  logic              ovr_any;
  logic [DATA_W-1:0] win_data;
  logic [4:0]        win_slot;
  logic [5:0]        pop_count;
  logic              hit_valid_reg;
  logic [4:0]        hit_slot_reg;
  logic [5:0]        active_count_reg;

  logic load_fire;
  logic slot_ok;

  assign load_fire = bus.load_valid && (state_reg == IDLE);
  assign slot_ok   = ({1'b0, bus.load_slot} < 6'(NUM_CODES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.clear_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        ptr_next = ptr_reg + 5'd1;
        if (ptr_reg == 5'(NUM_CODES - 1)) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A load coinciding with clear_req lands here first; the wipe then removes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        en_reg[i]     <= 1'b0;
        cmp_en_reg[i] <= 1'b0;
        addr_reg[i]   <= '0;
        cmp_reg[i]    <= '0;
        rep_reg[i]    <= '0;
      end
    end else if (state_reg == CLEAR) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        if (5'(i) == ptr_reg) begin
          en_reg[i]     <= 1'b0;
          cmp_en_reg[i] <= 1'b0;
          addr_reg[i]   <= '0;
          cmp_reg[i]    <= '0;
          rep_reg[i]    <= '0;
        end
      end
    end else if (load_fire && slot_ok) begin
      for (int i = 0; i < NUM_CODES; i++) begin
        if (5'(i) == bus.load_slot) begin
          en_reg[i]     <= bus.load_en;
          cmp_en_reg[i] <= bus.load_cmp_en;
          addr_reg[i]   <= bus.load_addr;
          cmp_reg[i]    <= bus.load_cmp;
          rep_reg[i]    <= bus.load_rep;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_match
    assign match[gi] = bus.enable && en_reg[gi]
                    && ({1'b1, addr_reg[gi]} == bus.bus_addr)
                    && (!cmp_en_reg[gi] || (cmp_reg[gi] == bus.bus_data));
  end

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    ovr_any  = 1'b0;
    win_data = '0;
    win_slot = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if (match[i]) begin
        ovr_any  = 1'b1;
        win_data = rep_reg[i];
        win_slot = 5'(i);
      end
    end
  end

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < NUM_CODES; i++) begin
      pop_count = pop_count + 6'(en_reg[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_valid_reg    <= 1'b0;
      hit_slot_reg     <= '0;
      active_count_reg <= '0;
    end else begin
      hit_valid_reg    <= bus.bus_rd && ovr_any;
      if (bus.bus_rd && ovr_any) begin
        hit_slot_reg <= win_slot;
      end
      active_count_reg <= pop_count;
    end
  end

  assign bus.load_ready   = (state_reg == IDLE);
  assign bus.clear_busy   = (state_reg == CLEAR);
  assign bus.ovr          = ovr_any;
  assign bus.ovr_data     = win_data;
  assign bus.hit_valid    = hit_valid_reg;
  assign bus.hit_slot     = hit_slot_reg;
  assign bus.active_count = active_count_reg;

endmodule
